// File: rtl/mixcolum_par.sv
// AES MixColumns / InvMixColumns over a captured 128-bit state, mixing
// COLS_PER_CYCLE columns per clock with optional registered output.
module mixcolum_par #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit REG_OUT        = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         decrypt_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [127:0] data_i,
    output logic         busy_o,
    output logic         ready_o,
    output logic [127:0] data_o
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mixcolum_par: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // STEP wraps to 0 for a 4-column batch, so the counter stays at 0.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] MASK = 2'(COLS_PER_CYCLE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic [127:0]   r_data;
    logic           r_mode;
    logic [1:0]     r_cnt;
    logic [127:0]   r_out;
    logic           r_ready;
    logic [127:0]   w_next_data;
    logic           w_done;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One output byte: p is the diagonal byte, q/s/t follow in column order.
    function automatic logic [7:0] mix_row(input logic [7:0] p, input logic [7:0] q,
                                           input logic [7:0] s, input logic [7:0] t,
                                           input logic inv);
        logic [7:0] p2, p4, p8, q2, q4, q8, s2, s4, s8, t2, t4, t8;
        p2 = xt(p); p4 = xt(p2); p8 = xt(p4);
        q2 = xt(q); q4 = xt(q2); q8 = xt(q4);
        s2 = xt(s); s4 = xt(s2); s8 = xt(s4);
        t2 = xt(t); t4 = xt(t2); t8 = xt(t4);
        if (inv)
            return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (s8 ^ s4 ^ s) ^ (t8 ^ t);
        else
            return p2 ^ (q2 ^ q) ^ s ^ t;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mix_row(a0, a1, a2, a3, inv), mix_row(a1, a2, a3, a0, inv),
                mix_row(a2, a3, a0, a1, inv), mix_row(a3, a0, a1, a2, inv)};
    endfunction

    // The counter is always a multiple of the batch size, so masking the
    // low bits of a column index identifies the batch it belongs to.
    always_comb begin
        w_next_data = r_data;
        for (int c = 0; c < 4; c++) begin
            if ((2'(c) & ~MASK) == r_cnt)
                w_next_data[127-32*c -: 32] = mix_col(r_data[127-32*c -: 32], r_mode);
        end
    end

    assign w_done = (r_state == RUN) && (r_cnt == LAST) && !abort_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        r_data  <= data_i;
                        r_mode  <= decrypt_i;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_data <= w_next_data;
                        r_cnt  <= r_cnt + STEP;
                        if (r_cnt == LAST) begin
                            r_state <= IDLE;
                            r_out   <= w_next_data;
                            r_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o  = (r_state == RUN);
    assign ready_o = REG_OUT ? r_ready : w_done;
    assign data_o  = (REG_OUT || !w_done) ? r_out : w_next_data;

endmodule

// File: doc/mixcolum_par.md
Name: mixcolum_par

Overview:
- Parametrised successor of the iterative AES MixColumns unit for the 128-bit AES datapath.
- Processes COLS_PER_CYCLE 32-bit columns per clock, so a full 128-bit state takes 4, 2 or 1 cycles.
- Latches input data and mode at start; the source is free to change data_i afterwards.
- Contains the forward/inverse GF(2^8) column mixer internally, adds busy_o and abort_i, and sits between ShiftRows and AddRoundKey in the round loop.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; any other value is a elaboration error.
- REG_OUT, 1, 1: data_o/ready_o come from flops. 0: the last batch bypasses the result register, saving one cycle of latency.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- decrypt_i  in  1  0 = MixColumns, 1 = InvMixColumns; sampled only on the accepting edge.
- start_i  in  1  start request; accepted only in IDLE.
- abort_i  in  1  synchronous abort of an in-flight operation.
- data_i  in  128  state; column c = data_i[127-32c -: 32]; row 0 byte at column MSB.
- busy_o  out  1  high while in RUN.
- ready_o  out  1  one-cycle done pulse.
- data_o  out  128  result; holds its value until the next completion.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low.
  - While reset is low: state = IDLE, busy_o = 0, ready_o = 0, data_o = 0, internal data/mode/column counter = 0.
- Let N = 4 / COLS_PER_CYCLE.
- States: IDLE and RUN.
- IDLE:
  - On an edge with start_i = 1, capture data_i and decrypt_i, set col_cnt = 0, go to RUN (this is the accepting edge E0).
  - busy_o rises after E0.
- RUN, one batch per edge:
  - Each edge mixes columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of the captured data.
  - Results are written back in place.
  - col_cnt advances by COLS_PER_CYCLE and wraps modulo 4.
  - On the N-th RUN edge (E0+N): state returns to IDLE, busy_o falls, the full 128-bit result loads into data_o, and ready_o = 1 for exactly one cycle.
  - REG_OUT = 0: ready_o and data_o are combinational during the last RUN cycle, one cycle earlier; the data_o value is held after that.
- start_i behaviour:
  - Ignored while in RUN; no queueing.
  - Accepted in the IDLE cycle in which ready_o is high, so back-to-back throughput is one result per N+1 cycles (REG_OUT = 1).
- abort_i:
  - abort_i = 1 on an edge in RUN: go to IDLE, no ready_o pulse, data_o unchanged.
  - abort_i has priority over completion.
  - abort_i in IDLE has priority over start_i, so a simultaneous start is dropped.
- Column arithmetic, GF(2^8) with polynomial 0x11B:
  - xtime(b) = (b << 1) ^ (b[7] ? 0x1B : 0).
  - Forward matrix rows: [02 03 01 01] rotated per row.
  - Inverse matrix rows: [0E 0B 0D 09] rotated per row.
  - Mode is the captured decrypt value, never the live decrypt_i.
- Changes to data_i or decrypt_i after E0 have no effect on the running operation.
- Reset asserted mid-operation: immediate return to reset values; no pulse on release.

Test Plan:
1. Forward, known-answer column vectors:
   - COLS_PER_CYCLE = 1, decrypt = 0, data_i = db135345_f20a225c_01010101_2d26314c.
   - Start pulse, then change data_i to random values the next cycle.
   - Required: ready_o at E0+4 with data_o = 8e4da1bc_9fdc589d_01010101_4d7ebdf8.
2. Inverse at full width:
   - COLS_PER_CYCLE = 4, decrypt = 1, data_i = the expected result from test 1.
   - Required: ready_o at E0+1 with data_o = db135345_f20a225c_01010101_2d26314c.
3. Back-to-back and busy behaviour:
   - COLS_PER_CYCLE = 2, decrypt = 0, c6c6c6c6 x4, then d4d4d4d5 x4 with start held high continuously.
   - Required: results c6c6c6c6 x4, then d5d5d7d6 x4, ready_o pulses 3 cycles apart, busy_o = 1 only in the RUN cycles.
4. Abort:
   - Start, then abort_i = 1 at E0+2 with COLS_PER_CYCLE = 1.
   - Required: no ready_o pulse, data_o keeps its previous value, busy_o = 0 at E0+2, and a subsequent start completes normally.
5. Asynchronous reset:
   - Assert reset mid-RUN (between clock edges).
   - Required: busy_o, ready_o and data_o go to 0 immediately; no ready_o after release.
   - Start ignored while reset is low.
6. REG_OUT = 0:
   - Rerun test 1.
   - Required: ready_o and the correct data_o during cycle E0+3, and data_o held afterwards.
